// File: rtl/io_peripheral_unit.sv
// Data-side IO responder: GPIO output/input, prescaled timer with compare match,
// and an 8N1 UART transmitter fed by a TX FIFO. Address bit 15 is the bus select and is ignored here.
module io_peripheral_unit #(
    parameter int unsigned CLK_DIV        = 868,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMER_PRESCALE = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] io_address,
    input  logic [15:0] io_write_value,
    input  logic        io_write_en,
    input  logic        io_read_en,
    output logic [15:0] io_read_value,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        uart_tx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] PRE_LAST = 16'(TIMER_PRESCALE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

    logic [15:0]      r_gpio_out, r_sync1, r_sync2;
    logic [15:0]      r_timer, r_presc, r_compare;
    logic             r_match, r_ovf;
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    tx_state_t        r_state;
    logic [15:0]      r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;

    logic [14:0] w_addr;
    logic        w_unused_addr_msb;
    logic        w_wr_gpio, w_wr_timer, w_wr_compare, w_wr_txdata, w_wr_status;
    logic        w_full, w_empty, w_push, w_pop, w_busy, w_baud_end, w_tick, w_set_match;

    assign w_addr            = io_address[14:0];
    assign w_unused_addr_msb = io_address[15];
    assign w_wr_gpio         = io_write_en && (w_addr == 15'd0);
    assign w_wr_timer        = io_write_en && (w_addr == 15'd2);
    assign w_wr_compare      = io_write_en && (w_addr == 15'd3);
    assign w_wr_txdata       = io_write_en && (w_addr == 15'd4);
    assign w_wr_status       = io_write_en && (w_addr == 15'd5);

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_baud_end = (r_baud == DIV_LAST);
    assign w_push     = w_wr_txdata && !w_full;
    assign w_pop      = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_end));
    assign w_tick     = (r_presc == PRE_LAST);
    // A load is compared against the loaded value; otherwise only a tick can produce a new value.
    assign w_set_match = w_wr_timer ? (io_write_value == r_compare)
                                    : (w_tick && ((r_timer + 16'd1) == r_compare));

    // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_compare  <= 16'hFFFF;
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (w_wr_gpio)    r_gpio_out <= io_write_value;
            if (w_wr_compare) r_compare  <= io_write_value;
            r_match <= (r_match & ~(w_wr_status & io_write_value[3])) | w_set_match;
            r_ovf   <= (r_ovf & ~(w_wr_status & io_write_value[4])) | (w_wr_txdata & w_full);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
            r_presc <= '0;
        end else if (w_wr_timer) begin
            r_timer <= io_write_value;
            r_presc <= '0;
        end else if (w_tick) begin
            r_timer <= r_timer + 16'd1;
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // NOTE: the storage array has no reset; the occupancy count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= io_write_value[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_fifo[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_fifo[r_rd_ptr];
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the default assignment comes first so every path drives the output and no latch forms.
    always_comb begin
        io_read_value = '0;
        if (io_read_en) begin
            case (w_addr)
                15'd0:   io_read_value = r_gpio_out;
                15'd1:   io_read_value = r_sync2;
                15'd2:   io_read_value = r_timer;
                15'd3:   io_read_value = r_compare;
                15'd5:   io_read_value = {11'd0, r_ovf, r_match, w_busy, w_empty, w_full};
                default: io_read_value = '0;
            endcase
        end
    end

    assign gpio_out = r_gpio_out;
    assign uart_tx  = r_tx;
endmodule

// File: tb/tb_io_peripheral_unit.sv
// Self-checking bench for io_peripheral_unit: a transaction-level model (byte queue, frame timer,
// elapsed-cycle timer) is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_io_peripheral_unit;
    localparam int D     = 4;
    localparam int DEPTH = 8;
    localparam int P     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_address, io_write_value, io_read_value, gpio_in, gpio_out;
    logic        io_write_en, io_read_en, uart_tx;

    int n_checks = 0;
    int n_fail   = 0;

    io_peripheral_unit #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .TIMER_PRESCALE(P)) dut (
        .clk           (clk),
        .rst           (rst),
        .io_address    (io_address),
        .io_write_value(io_write_value),
        .io_write_en   (io_write_en),
        .io_read_en    (io_read_en),
        .io_read_value (io_read_value),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .uart_tx       (uart_tx)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic        m_valid = 1'b0;
    logic [15:0] m_gpio_out, m_gin_d1, m_gin_d2, m_compare, m_timer_base;
    int          m_since_load;
    logic        m_match, m_ovf, m_busy;
    logic [7:0]  m_q[$];
    logic [7:0]  m_frame_byte;
    int          m_frame_t;

    logic        seen_tx;
    logic [15:0] seen_gpio;
    logic [15:0] g_gpio;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_timer();
        return m_timer_base + 16'(m_since_load / P);
    endfunction

    // Line level from the position inside the current 10-bit frame.
    function automatic logic model_tx();
        int idx;
        if (!m_busy) return 1'b1;
        idx = m_frame_t / D;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return m_frame_byte[idx-1];
    endfunction

    function automatic logic [15:0] model_read();
        logic [15:0] v;
        v = '0;
        if (io_read_en) begin
            case (io_address[14:0])
                15'd0:   v = m_gpio_out;
                15'd1:   v = m_gin_d2;
                15'd2:   v = model_timer();
                15'd3:   v = m_compare;
                15'd5:   v = {11'd0, m_ovf, m_match, m_busy, m_q.size() == 0, m_q.size() == DEPTH};
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        logic [14:0] a;
        logic        set_m, ovf_s, full_pre, pop;
        if (rst) begin
            m_gpio_out = '0; m_gin_d1 = '0; m_gin_d2 = '0; m_compare = 16'hFFFF;
            m_timer_base = '0; m_since_load = 0; m_match = 0; m_ovf = 0;
            m_busy = 0; m_frame_t = 0; m_q.delete();
            return;
        end
        a = io_address[14:0];
        m_gin_d2 = m_gin_d1;
        m_gin_d1 = gpio_in;
        if (io_write_en && a == 15'd0) m_gpio_out = io_write_value;
        set_m = 1'b0;
        if (io_write_en && a == 15'd2) begin
            m_timer_base = io_write_value;
            m_since_load = 0;
            set_m = (io_write_value == m_compare);
        end else begin
            m_since_load++;
            if (m_since_load % P == 0) set_m = (model_timer() == m_compare);
        end
        if (io_write_en && a == 15'd3) m_compare = io_write_value;
        full_pre = (m_q.size() == DEPTH);
        pop = (m_q.size() != 0) && (!m_busy || m_frame_t == 10*D - 1);
        if (m_busy && m_frame_t == 10*D - 1 && !pop) m_busy = 1'b0;
        else if (pop) begin
            m_frame_byte = m_q.pop_front();
            m_busy = 1'b1;
            m_frame_t = 0;
        end else if (m_busy) m_frame_t++;
        ovf_s = 1'b0;
        if (io_write_en && a == 15'd4) begin
            if (full_pre) ovf_s = 1'b1;
            else m_q.push_back(io_write_value[7:0]);
        end
        m_match = (m_match & ~(io_write_en && a == 15'd5 && io_write_value[3])) | set_m;
        m_ovf   = (m_ovf & ~(io_write_en && a == 15'd5 && io_write_value[4])) | ovf_s;
    endtask

    // One bus cycle: check registered outputs, drive inputs, check the combinational read, step model.
    task automatic cycle(input logic c_rst, input logic [15:0] c_addr, input logic [15:0] c_wd,
                         input logic c_we, input logic c_re);
        @(negedge clk);
        seen_tx   = uart_tx;
        seen_gpio = gpio_out;
        if (m_valid) begin
            check("uart_tx", {15'd0, uart_tx}, {15'd0, model_tx()});
            check("gpio_out", gpio_out, m_gpio_out);
        end
        rst = c_rst; io_address = c_addr; io_write_value = c_wd;
        io_write_en = c_we; io_read_en = c_re; gpio_in = g_gpio;
        #1;
        if (m_valid) check("io_read_value", io_read_value, model_read());
        model_step();
        if (c_rst) m_valid = 1'b1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        cycle(1'b0, addr, data, 1'b1, 1'b0);
    endtask

    task automatic rd_expect(input string name, input logic [15:0] addr, input logic [15:0] exp);
        cycle(1'b0, addr, 16'h0, 1'b0, 1'b1);
        check(name, io_read_value, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_reset [6];
        logic [9:0]  pat;
        int          k, code;
        logic [15:0] addr, data;
        logic        we, re, rr;

        rst = 1'b1; io_address = '0; io_write_value = '0;
        io_write_en = 1'b0; io_read_en = 1'b0; g_gpio = '0; gpio_in = '0;
        cycle(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

        // Reset state of every register, line idle high, outputs cleared.
        exp_reset = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0002};
        for (int i = 0; i < 6; i++) rd_expect("reset read", 16'h8000 | 16'(i), exp_reset[i]);
        check("reset uart_tx", {15'd0, seen_tx}, 16'h0001);
        check("reset gpio_out", seen_gpio, 16'h0000);

        // GPIO output write, simultaneous read+write, and the two-flop input synchroniser.
        wr(16'h8000, 16'hA5C3);
        rd_expect("gpio_out readback", 16'h8000, 16'hA5C3);
        check("gpio_out pin", seen_gpio, 16'hA5C3);
        cycle(1'b0, 16'h0000, 16'h1111, 1'b1, 1'b1);
        check("read during write", io_read_value, 16'hA5C3);
        g_gpio = 16'h1234;
        rd_expect("gpio_in +0", 16'h0001, 16'h0000);
        rd_expect("gpio_in +1", 16'h0001, 16'h0000);
        rd_expect("gpio_in +2", 16'h0001, 16'h1234);

        // 0x55 frame: idle one edge, then 0,1,0,1,0,1,0,1,0,1 each D clocks, then idle.
        pat = 10'b1010101010;
        wr(16'h0004, 16'h0055);
        for (int j = 0; j < 42; j++) begin
            idle(1);
            if (j == 0 || j == 41) check("frame idle", {15'd0, seen_tx}, 16'h0001);
            else check("frame bit", {15'd0, seen_tx}, {15'd0, pat[(j-1)/D]});
        end

        // TX busy: 8 bytes fill the FIFO, the 9th overflows; W1C clears only the sticky bit.
        wr(16'h0004, 16'h0011);
        idle(1);
        for (int i = 0; i < 9; i++) wr(16'h0004, 16'h0020 + 16'(i));
        rd_expect("status overflow", 16'h0005, 16'h0015);
        wr(16'h0005, 16'h0010);
        rd_expect("status ovf cleared", 16'h0005, 16'h0005);
        idle(400);
        rd_expect("status drained", 16'h0005, 16'h0002);

        // TX idle: first byte popped early, so nine back-to-back writes all fit.
        for (int i = 0; i < 9; i++) wr(16'h0004, 16'h0040 + 16'(i));
        rd_expect("status 9 writes", 16'h0005, 16'h0005);
        idle(400);
        rd_expect("status drained 2", 16'h0005, 16'h0002);

        // Timer: load 3 with COMPARE 5 matches two ticks (2*P edges) later.
        wr(16'h0003, 16'h0005);
        wr(16'h0002, 16'h0003);
        rd_expect("timer load", 16'h0002, 16'h0003);
        idle(4);
        rd_expect("status before match", 16'h0005, 16'h0002);
        rd_expect("status match", 16'h0005, 16'h000A);
        wr(16'h0005, 16'h0008);
        rd_expect("match cleared", 16'h0005, 16'h0002);
        wr(16'h0002, 16'h0003);
        idle(5);
        wr(16'h0005, 16'h0008);
        rd_expect("set beats clear", 16'h0005, 16'h000A);
        wr(16'h0005, 16'h0008);
        rd_expect("match cleared 2", 16'h0005, 16'h0002);

        // Reset during data bit 4 of a 0x0F frame with three bytes queued.
        wr(16'h0004, 16'h000F);
        wr(16'h0004, 16'h0081);
        wr(16'h0004, 16'h0082);
        wr(16'h0004, 16'h0083);
        idle(19);
        cycle(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        check("line low before reset", {15'd0, seen_tx}, 16'h0000);
        rd_expect("status after reset", 16'h0005, 16'h0002);
        check("line high after reset", {15'd0, seen_tx}, 16'h0001);
        check("gpio_out after reset", seen_gpio, 16'h0000);
        idle(60);
        check("no frames after reset", {15'd0, seen_tx}, 16'h0001);
        rd_expect("status still idle", 16'h0005, 16'h0002);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            k    = int'($urandom_range(0, 99));
            code = int'($urandom_range(0, 7));
            if (code == 7) addr = {1'($urandom), 15'($urandom_range(8, 32767))};
            else addr = {1'($urandom), 15'(code)};
            data = 16'($urandom);
            if (code == 2) data = m_compare - 16'($urandom_range(0, 3));
            if (code == 3) data = 16'($urandom_range(0, 40));
            we = (k < 40);
            re = 1'($urandom);
            rr = (k == 99) && ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) g_gpio = 16'($urandom);
            cycle(rr, addr, data, we, re);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
